// File: rtl/counter_cmd_sequencer_if.sv
// Command channel for counter_cmd_sequencer: valid/ready handshake carrying
// {op, data, len}. The master issues commands and the slave (sequencer) accepts them.
interface counter_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: buffers counter commands in a small FIFO and drives
// the up/down counter's enable/preload/preload_data/mode pins cycle-accurately.
// Optional feature macro SEQ_DETECT_STOP_EN: detect terminates a RUN early and
// pulses aborted together with done. Without it, detect is ignored.
module counter_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  counter_cmd_sequencer_if.slave  cmd,
  input  logic                    detect,
  output logic                    enable,
  output logic                    preload,
  output logic [WIDTH-1:0]        preload_data,
  output logic                    mode,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_LOAD = 2'b01, OP_UP = 2'b10, OP_DOWN = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  state_e state;

  logic [1:0]       op_mem   [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [LEN_W-1:0] len_mem  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [LEN_W-1:0] remaining;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  op_e              head_op;
  logic [WIDTH-1:0] head_data;
  logic [LEN_W-1:0] head_len;
  logic             head_active;
  logic             stop_req;
  logic             finishing;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign push      = cmd.cmd_valid && !full;
  assign cmd.cmd_ready = !full;
  assign busy      = (state != S_IDLE) || !empty;

  assign head_op   = op_e'(op_mem[rd_ptr]);
  assign head_data = data_mem[rd_ptr];
  assign head_len  = len_mem[rd_ptr];

`ifdef SEQ_DETECT_STOP_EN
  assign stop_req = (state == S_RUN) && enable && detect;
`else
  logic unused_detect;
  assign unused_detect = detect;
  assign stop_req = 1'b0;
`endif

  // Commands with at least one active output cycle chain directly onto the
  // completion edge; NOP and zero-length RUNs wait for IDLE so their done
  // pulse stays separate from the previous command's.
  assign head_active = (head_op == OP_LOAD) ||
                       ((head_op == OP_UP || head_op == OP_DOWN) && head_len != '0);
  assign finishing   = (state == S_LOAD) ||
                       ((state == S_RUN) && (remaining == LEN_W'(1) || stop_req));
  assign pop         = !empty && ((state == S_IDLE) || (finishing && head_active));

  // FIFO storage writes (no reset needed; validity tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= cmd.cmd_op;
      data_mem[wr_ptr] <= cmd.cmd_data;
      len_mem[wr_ptr]  <= cmd.cmd_len;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM with registered counter-facing outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      enable       <= 1'b0;
      preload      <= 1'b0;
      preload_data <= '0;
      mode         <= 1'b1;
      done         <= 1'b0;
      aborted      <= 1'b0;
      remaining    <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;

      case (state)
        S_LOAD: begin
          preload <= 1'b0;
          done    <= 1'b1;
          state   <= S_IDLE;
        end
        S_RUN: begin
          if (remaining == LEN_W'(1) || stop_req) begin
            enable    <= 1'b0;
            done      <= 1'b1;
            aborted   <= stop_req && (remaining != LEN_W'(1));
            remaining <= '0;
            state     <= S_IDLE;
          end else begin
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase

      // A pop overrides the completion updates above so the next command
      // starts on the same edge without a gap.
      if (pop) begin
        case (head_op)
          OP_NOP: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          OP_LOAD: begin
            preload      <= 1'b1;
            preload_data <= head_data;
            state        <= S_LOAD;
          end
          default: begin
            mode      <= (head_op == OP_UP);
            remaining <= head_len;
            if (head_len != '0) begin
              enable <= 1'b1;
              state  <= S_RUN;
            end else begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Self-checking bench for counter_cmd_sequencer: table of single-command
// vectors plus hand-written back-to-back, FIFO-full and mid-RUN reset sequences.
module tb_counter_cmd_sequencer;
  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
  localparam int DEPTH = 4;

`ifdef SEQ_DETECT_STOP_EN
  localparam int DET_EN = 4;
  localparam int DET_AB = 1;
`else
  localparam int DET_EN = 10;
  localparam int DET_AB = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             detect;
  logic             enable;
  logic             preload;
  logic [WIDTH-1:0] preload_data;
  logic             mode;
  logic             busy;
  logic             done;
  logic             aborted;

  counter_cmd_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) cif ();

  counter_cmd_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cif.slave),
    .detect       (detect),
    .enable       (enable),
    .preload      (preload),
    .preload_data (preload_data),
    .mode         (mode),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [1:0] op;
    int data;
    int len;
    int det_at;
    int exp_pre;
    int exp_en;
    int exp_mode;
    int exp_pd;
    int exp_ab;
  } vec_t;

  vec_t vecs[7];

  task automatic drive_cmd(input logic [1:0] op, input int data, input int len);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data[WIDTH-1:0];
    cif.cmd_len   = len[LEN_W-1:0];
  endtask

  // Push one command from idle and observe a fixed window of cycles.
  task automatic run_vec(input vec_t v, output int pre, output int en, output int dn,
                         output int dn_idx, output int ab, output int ovl,
                         output int mode_end, output int pd_end);
    pre = 0; en = 0; dn = 0; dn_idx = -1; ab = 0; ovl = 0;
    @(negedge clk);
    drive_cmd(v.op, v.data, v.len);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (preload) pre++;
      if (enable) en++;
      if (done) begin dn++; dn_idx = i; end
      if (aborted) ab++;
      if (preload && enable) ovl++;
      detect = (v.det_at != 0) && enable && (en == v.det_at);
      @(negedge clk);
    end
    detect   = 1'b0;
    mode_end = int'(mode);
    pd_end   = int'(preload_data);
  endtask

  initial begin
    int pre, en, dn, dn_idx, ab, ovl, mode_end, pd_end;

    vecs[0] = '{2'b01, 10, 0,  0, 1, 0,      1, 10, 0};
    vecs[1] = '{2'b10, 0,  5,  0, 0, 5,      1, 10, 0};
    vecs[2] = '{2'b11, 0,  3,  0, 0, 3,      0, 10, 0};
    vecs[3] = '{2'b00, 0,  0,  0, 0, 0,      0, 10, 0};
    vecs[4] = '{2'b10, 0,  0,  0, 0, 0,      1, 10, 0};
    vecs[5] = '{2'b01, 5,  0,  0, 1, 0,      1, 5,  0};
    vecs[6] = '{2'b10, 0,  10, 4, 0, DET_EN, 1, 5,  DET_AB};

    reset = 1'b1;
    detect = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op = '0;
    cif.cmd_data = '0;
    cif.cmd_len = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_enable", int'(enable), 0);
    check("rst_preload", int'(preload), 0);
    check("rst_pdata", int'(preload_data), 0);
    check("rst_mode", int'(mode), 1);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cif.cmd_ready), 1);

    // Table-driven single commands
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], pre, en, dn, dn_idx, ab, ovl, mode_end, pd_end);
      check($sformatf("v%0d_preload_cycles", i), pre, vecs[i].exp_pre);
      check($sformatf("v%0d_enable_cycles", i), en, vecs[i].exp_en);
      check($sformatf("v%0d_done_count", i), dn, 1);
      check($sformatf("v%0d_done_cycle", i), dn_idx, 1 + vecs[i].exp_pre + vecs[i].exp_en);
      check($sformatf("v%0d_aborted", i), ab, vecs[i].exp_ab);
      check($sformatf("v%0d_overlap", i), ovl, 0);
      check($sformatf("v%0d_mode", i), mode_end, vecs[i].exp_mode);
      check($sformatf("v%0d_pdata_hold", i), pd_end, vecs[i].exp_pd);
    end

    // Back-to-back: LOAD 3, RUN_DOWN 2, NOP
    begin
      int bpre = 0, ben = 0, bdown = 0, bdn = 0, last_pre = -1, first_en = -1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (preload) begin bpre++; last_pre = i; end
        if (enable) begin
          ben++;
          if (first_en < 0) first_en = i;
          if (!mode) bdown++;
        end
        if (done) bdn++;
        case (i)
          0: drive_cmd(2'b01, 3, 0);
          1: drive_cmd(2'b11, 0, 2);
          2: drive_cmd(2'b00, 0, 0);
          3: cif.cmd_valid = 1'b0;
          default: ;
        endcase
      end
      check("b2b_preload_cycles", bpre, 1);
      check("b2b_enable_cycles", ben, 2);
      check("b2b_enable_down", bdown, 2);
      check("b2b_no_gap", first_en, last_pre + 1);
      check("b2b_done_count", bdn, 3);
      check("b2b_pdata", int'(preload_data), 3);
      check("b2b_busy_end", int'(busy), 0);
    end

    // FIFO full: RUN_UP 20 stalls the FSM while five LOADs are offered
    begin
      int k = 0, first_block = -1, fifth_ok = 0, nseq = 0, seen_en = 0;
      int seq[8];
      @(negedge clk);
      drive_cmd(2'b10, 0, 20);
      @(negedge clk);
      cif.cmd_valid = 1'b0;
      for (int i = 0; i < 10 && !seen_en; i++) begin
        @(negedge clk);
        if (enable) seen_en = 1;
      end
      check("full_run_started", seen_en, 1);
      for (int i = 0; i < 80; i++) begin
        if (preload) begin
          if (nseq < 8) seq[nseq] = int'(preload_data);
          nseq++;
        end
        if (k < 5) begin
          drive_cmd(2'b01, k + 1, 0);
          if (!cif.cmd_ready && first_block < 0) first_block = k;
          if (cif.cmd_ready) begin
            if (k == 4) fifth_ok = int'(preload && preload_data == 4'd1);
            k++;
          end
        end else begin
          cif.cmd_valid = 1'b0;
        end
        @(negedge clk);
      end
      cif.cmd_valid = 1'b0;
      check("full_blocked_after", first_block, 4);
      check("full_fifth_after_pop", fifth_ok, 1);
      check("full_accepted", k, 5);
      check("full_loads_seen", nseq, 5);
      for (int j = 0; j < 5; j++)
        check($sformatf("full_order%0d", j), (j < nseq) ? seq[j] : -1, j + 1);
    end

    // Reset three cycles into RUN_DOWN 10 with a LOAD still queued
    begin
      int encnt = 0, post_done = 0, post_pre = 0;
      @(negedge clk);
      drive_cmd(2'b11, 0, 10);
      @(negedge clk);
      drive_cmd(2'b01, 7, 0);
      @(negedge clk);
      cif.cmd_valid = 1'b0;
      for (int i = 0; i < 20 && encnt < 3; i++) begin
        if (enable) encnt++;
        if (encnt < 3) @(negedge clk);
      end
      check("rrun_enable_cycles", encnt, 3);
      check("rrun_mode_before", int'(mode), 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rrun_enable", int'(enable), 0);
      check("rrun_mode", int'(mode), 1);
      check("rrun_busy", int'(busy), 0);
      check("rrun_ready", int'(cif.cmd_ready), 1);
      check("rrun_done", int'(done), 0);
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (done) post_done++;
        if (preload || enable) post_pre++;
      end
      check("rrun_no_done", post_done, 0);
      check("rrun_fifo_dropped", post_pre, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
